// File: rtl/moore_seq_pkg.sv
// Shared limits and width helper for the Moore sequence detector.
package moore_seq_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 1;
  localparam int CNT_W_MAX   = 32;

  // Number of bits needed to hold values 0..n-1.
  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/moore_seq_detector_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_q, count_d;

  // Next count with saturation at the top value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/moore_seq_detector.sv
// Serial pattern detector: registered Moore machine over {history, fill},
// with a loadable pattern, overlap control and a saturating match counter.
module moore_seq_detector
  import moore_seq_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1011,
  parameter int                 CNT_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic                              in_w,
  input  logic                              pat_load,
  input  logic [PAT_LEN-1:0]                pat_value,
  input  logic                              overlap_en,
  output logic                              match,
  output logic [CNT_W-1:0]                  match_count,
  output logic [clog2_w(PAT_LEN+1)-1:0]     fill
);

  localparam int             FW       = clog2_w(PAT_LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0]  FILL_ONE = FW'(1);

  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX) ||
      (CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_bad_params
    $error("moore_seq_detector: PAT_LEN or CNT_W out of range");
  end

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;

  // Next state: load has priority over a serial bit; match_d is the match event.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (pat_load) begin
      pat_d  = pat_value;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = {hist_q[PAT_LEN-2:0], in_w};
      fill_d = (fill_q == FILL_MAX) ? FILL_MAX : (fill_q + FILL_ONE);
      if ((fill_d == FILL_MAX) && (hist_d == pat_q)) begin
        match_d = 1'b1;
        // Non-overlap restarts the window; history keeps shifting regardless.
        if (!overlap_en) fill_d = '0;
        else             fill_d = FILL_MAX;
      end else begin
        match_d = 1'b0;
      end
    end else begin
      match_d = 1'b0;
    end
  end

  // State and registered match output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_d),
    .count (match_count)
  );

  assign match = match_q;
  assign fill  = fill_q;

endmodule
